// File: rtl/neuron_weight_sequencer_if.sv
// Bus bundle for neuron_weight_sequencer. The bundle carries the command/status
// lines, the activation stream, the weight ROM port and the MAC pair output.
// The master view belongs to the sequencer. The slave view belongs to its
// surroundings: the command source, the activation source, the ROM and the MAC.
interface neuron_weight_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              x_valid;
    logic [DATA_W-1:0] x_data;
    logic              x_ready;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_radd;
    logic [DATA_W-1:0] mem_rdata;
    logic              pair_valid;
    logic [DATA_W-1:0] pair_w;
    logic [DATA_W-1:0] pair_x;
    logic              pair_last;

    modport master (
        input  start, abort, x_valid, x_data, mem_rdata,
        output busy, done, x_ready, mem_ren, mem_radd,
               pair_valid, pair_w, pair_x, pair_last
    );

    modport slave (
        output start, abort, x_valid, x_data, mem_rdata,
        input  busy, done, x_ready, mem_ren, mem_radd,
               pair_valid, pair_w, pair_x, pair_last
    );
endinterface

// File: rtl/neuron_weight_sequencer.sv
// Weight sequencer for one neuron. Each accepted activation triggers one read
// of the synchronous weight ROM. The activation is delayed one cycle so that it
// lines up with the registered ROM data. The aligned {weight, activation} pair
// goes to the MAC; the final pair is flagged, and done pulses one cycle later.
module neuron_weight_sequencer #(
    parameter int NUM_WEIGHT = 30,
    parameter int ADDR_W     = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1,
    parameter int DATA_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    neuron_weight_sequencer_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr;
    logic              rdy;
    logic              busy_c;
    logic              done_c;
    logic              hs;
    logic              at_last;

    // Stage p1: the activation, valid and last flag, aligned to the ROM output register
    logic [DATA_W-1:0] x_p1;
    logic              vld_p1;
    logic              last_p1;

    assign hs      = bus.x_valid & rdy;
    assign at_last = (addr == LAST_ADDR);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next state and control outputs; abort overrides every transition and masks the handshake
    always_comb begin
        state_n = state;
        rdy     = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && !bus.abort) state_n = S_RUN;
            end
            S_RUN: begin
                busy_c = 1'b1;
                rdy    = !bus.abort;
                if (bus.abort)                  state_n = S_IDLE;
                else if (bus.x_valid && at_last) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                busy_c  = 1'b1;
                state_n = bus.abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done_c  = !bus.abort;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Read address: clears at start, end or abort; advances per handshake; holds at the last index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (bus.abort || state == S_DONE || (state == S_IDLE && bus.start)) begin
            addr <= '0;
        end else if (hs && !at_last) begin
            addr <= addr + 1'b1;
        end
    end

    // Stage p0 -> p1: capture the accepted activation while the ROM registers its weight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_p1    <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1 <= hs;
            if (hs) begin
                x_p1    <= bus.x_data;
                last_p1 <= at_last;
            end
        end
    end

    assign bus.x_ready    = rdy;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.mem_ren    = hs;
    assign bus.mem_radd   = addr;
    assign bus.pair_valid = vld_p1;
    assign bus.pair_w     = bus.mem_rdata;
    assign bus.pair_x     = x_p1;
    assign bus.pair_last  = vld_p1 & last_p1;
endmodule

// File: tb/tb_neuron_weight_sequencer.sv
// Directed bench for neuron_weight_sequencer. It drives a 30-weight instance
// through clean, stalled, restart-attempt, abort and mid-run reset evaluations.
// It also drives a separate single-weight instance.
module tb_neuron_weight_sequencer;
    localparam int NW = 30;
    localparam int DW = 16;
    localparam int AW = $clog2(NW);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    neuron_weight_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) b ();
    neuron_weight_sequencer #(.NUM_WEIGHT(NW), .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(b)
    );

    neuron_weight_sequencer_if #(.DATA_W(DW), .ADDR_W(1)) b1 ();
    neuron_weight_sequencer #(.NUM_WEIGHT(1), .ADDR_W(1), .DATA_W(DW)) u_one (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );

    // ROM models: mem[k] = 3k for the main instance, a fixed word for the single-weight one
    logic [DW-1:0] rom [NW];
    initial for (int k = 0; k < NW; k++) rom[k] = DW'(3 * k);
    always @(posedge clk) if (b.mem_ren)  b.mem_rdata  <= rom[b.mem_radd];
    always @(posedge clk) if (b1.mem_ren) b1.mem_rdata <= 16'h00AB;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int feed_start = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          hs_c[$], ren_c[$], radd[$], p_c[$], d_c[$];
    logic [15:0] pw[$], px[$];
    bit          pl[$], dbusy[$];

    // Event log, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (b.x_valid && b.x_ready) hs_c.push_back(cyc);
            if (b.mem_ren) begin
                ren_c.push_back(cyc);
                radd.push_back(int'(b.mem_radd));
            end
            if (b.pair_valid) begin
                p_c.push_back(cyc);
                pw.push_back(b.pair_w);
                px.push_back(b.pair_x);
                pl.push_back(b.pair_last);
            end
            if (b.done) begin
                d_c.push_back(cyc);
                dbusy.push_back(b.busy);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW+DW+5:0] outs_vec();
        return {b.busy, b.done, b.x_ready, b.mem_ren, b.mem_radd,
                b.pair_valid, b.pair_x, b.pair_last};
    endfunction

    task automatic clear_logs();
        hs_c.delete(); ren_c.delete(); radd.delete(); p_c.delete(); d_c.delete();
        pw.delete(); px.delete(); pl.delete(); dbusy.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        b.start = 1'b1;
        tick(1);
        b.start = 1'b0;
    endtask

    // Streams up to n activations (x = k+1); stall bit j idles cycle j; optional hooks
    task automatic feed(input int n, input logic [63:0] stall, input int start_at,
                        input int abort_at, input int reset_at);
        int k;
        int j;
        bit acc;
        k = 0;
        j = 0;
        feed_start = cyc;
        while (k < n && j < 200) begin
            b.x_valid = (j < 64) ? !stall[j] : 1'b1;
            b.x_data  = DW'(k + 1);
            b.start   = (k == start_at);
            b.abort   = (k == abort_at);
            if (k == reset_at) begin
                #2 rst_n = 1'b0;
                #1 chk("rst_async_outs", outs_vec(), '0);
                tick(1);
                chk("rst_held_outs", outs_vec(), '0);
                rst_n = 1'b1;
                break;
            end
            #1 acc = b.x_valid && b.x_ready;
            tick(1);
            if (k == abort_at) begin
                chk("abort_discard", acc, 0);
                chk("abort_busy", b.busy, 0);
                break;
            end
            if (acc) k++;
            j++;
        end
        b.x_valid = 1'b0;
        b.start   = 1'b0;
        b.abort   = 1'b0;
        if (j >= 200) chk("feed_timeout", 1, 0);
    endtask

    task automatic drain(input bit start_in_done);
        tick(1);
        if (start_in_done) b.start = 1'b1;
        tick(1);
        b.start = 1'b0;
        tick(3);
        chk("idle_busy", b.busy, 0);
    endtask

    task automatic check_run(input string t, input int n, input bit full);
        int m;
        chk({t, "_hs_n"},   hs_c.size(),  n);
        chk({t, "_pair_n"}, p_c.size(),   n);
        chk({t, "_ren_n"},  ren_c.size(), n);
        m = n;
        if (hs_c.size() < m)  m = hs_c.size();
        if (p_c.size() < m)   m = p_c.size();
        if (ren_c.size() < m) m = ren_c.size();
        for (int k = 0; k < m; k++) begin
            chk($sformatf("%s_w%0d", t, k),    pw[k],    64'(3 * k));
            chk($sformatf("%s_x%0d", t, k),    px[k],    64'(k + 1));
            chk($sformatf("%s_last%0d", t, k), pl[k],    64'(full && k == n - 1));
            chk($sformatf("%s_lat%0d", t, k),  p_c[k],   64'(hs_c[k] + 1));
            chk($sformatf("%s_radd%0d", t, k), radd[k],  64'(k));
            chk($sformatf("%s_ren%0d", t, k),  ren_c[k], 64'(hs_c[k]));
        end
        if (full) begin
            chk({t, "_done_n"}, d_c.size(), 1);
            if (d_c.size() > 0 && hs_c.size() >= n) begin
                chk({t, "_done_lat"},  d_c[0],   64'(hs_c[n-1] + 2));
                chk({t, "_done_busy"}, dbusy[0], 0);
            end
        end else begin
            chk({t, "_done_n"}, d_c.size(), 0);
        end
    endtask

    initial begin
        logic [63:0] mask;
        int ej;
        int np;
        b.start = 0; b.abort = 0; b.x_valid = 0; b.x_data = '0;
        b1.start = 0; b1.abort = 0; b1.x_valid = 0; b1.x_data = '0;

        tick(2);
        chk("reset_outs", outs_vec(), '0);
        rst_n = 1'b1;
        tick(1);

        // start and abort together in IDLE: stay idle
        b.start = 1'b1; b.abort = 1'b1;
        tick(1);
        b.start = 1'b0; b.abort = 1'b0;
        chk("idle_abort_wins", b.busy, 0);
        tick(1);

        // clean back-to-back run
        clear_logs(); do_start();
        feed(30, '0, -1, -1, -1);
        drain(1'b0);
        check_run("clean", 30, 1'b1);
        if (p_c.size() == 30) chk("clean_consec", p_c[29] - p_c[0], 29);

        // stalls on stream cycles 5 and 12..14
        mask = '0;
        mask[5] = 1'b1; mask[12] = 1'b1; mask[13] = 1'b1; mask[14] = 1'b1;
        clear_logs(); do_start();
        feed(30, mask, -1, -1, -1);
        drain(1'b0);
        check_run("stall", 30, 1'b1);
        ej = 0;
        for (int k = 0; k < ren_c.size() && k < 30; k++) begin
            while (mask[ej]) ej++;
            chk($sformatf("stall_rencyc%0d", k), ren_c[k] - feed_start, ej);
            ej++;
        end

        // start mid-run and during DONE are ignored
        clear_logs(); do_start();
        feed(30, '0, 10, -1, -1);
        drain(1'b1);
        check_run("restart", 30, 1'b1);

        // abort after 17 handshakes, then a clean run
        clear_logs(); do_start();
        feed(30, '0, -1, 17, -1);
        drain(1'b0);
        check_run("abort", 17, 1'b0);
        clear_logs(); do_start();
        feed(30, '0, -1, -1, -1);
        drain(1'b0);
        check_run("post_abort", 30, 1'b1);

        // asynchronous reset at activation 20, stays idle, then a clean run
        clear_logs(); do_start();
        feed(30, '0, -1, -1, 20);
        np = p_c.size();
        b.x_valid = 1'b1;
        tick(3);
        chk("post_rst_busy",  b.busy,    0);
        chk("post_rst_ready", b.x_ready, 0);
        b.x_valid = 1'b0;
        chk("post_rst_pairs", p_c.size(), np);
        chk("post_rst_done",  d_c.size(), 0);
        clear_logs(); do_start();
        feed(30, '0, -1, -1, -1);
        drain(1'b0);
        check_run("post_rst", 30, 1'b1);

        // single-weight instance
        b1.start = 1'b1;
        tick(1);
        b1.start = 1'b0;
        chk("one_ready", b1.x_ready, 1);
        b1.x_valid = 1'b1; b1.x_data = 16'h1234;
        #1;
        chk("one_ren",  b1.mem_ren,  1);
        chk("one_radd", b1.mem_radd, 0);
        tick(1);
        b1.x_valid = 1'b0;
        chk("one_pvalid", b1.pair_valid, 1);
        chk("one_plast",  b1.pair_last,  1);
        chk("one_px",     b1.pair_x,     16'h1234);
        chk("one_pw",     b1.pair_w,     16'h00AB);
        chk("one_done_early", b1.done,   0);
        chk("one_busy",   b1.busy,       1);
        tick(1);
        chk("one_done",   b1.done,       1);
        chk("one_done_busy", b1.busy,    0);
        chk("one_pvalid_off", b1.pair_valid, 0);
        tick(1);
        chk("one_done_off", b1.done,     0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/neuron_weight_sequencer.md
Name: neuron_weight_sequencer

Overview:
- Controls one neuron's weight ROM (synchronous-read, 1-cycle latency, `ren`-gated output register).
- Accepts a start command and consumes NUM_WEIGHT input activations over a valid/ready stream.
- For each accepted activation, issues exactly one ROM read.
- Delivers time-aligned {weight, activation} pairs to the downstream MAC, flags the last pair, and pulses done.

Parameters:
- NUM_WEIGHT, 30, number of weights and activations per neuron evaluation.
- ADDR_W, $clog2(NUM_WEIGHT), ROM address width.
- DATA_W, 16, weight and activation width (Q-format fixed point, passed through untouched).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin evaluation; sampled only in IDLE.
- abort  in  1  synchronous abandon; returns to IDLE next edge.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse after the last pair.
- x_valid  in  1  activation available.
- x_data  in  DATA_W  activation value.
- x_ready  out  1  sequencer accepts activation.
- mem_ren  out  1  ROM read enable.
- mem_radd  out  ADDR_W  ROM read address.
- mem_rdata  in  DATA_W  ROM registered read data, valid 1 cycle after mem_ren.
- pair_valid  out  1  pair_w/pair_x valid this cycle.
- pair_w  out  DATA_W  weight (combinationally equal to mem_rdata).
- pair_x  out  DATA_W  activation aligned to pair_w.
- pair_last  out  1  qualifies final pair (index NUM_WEIGHT-1).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, addr=0, x_q=0, v_q=0, last_q=0.
  - Outputs: busy=0, done=0, x_ready=0, mem_ren=0, mem_radd=0, pair_valid=0, pair_x=0, pair_last=0.
- States:
  - IDLE: x_ready=0. If start=1 → RUN, addr<=0.
  - RUN: x_ready=1. Handshake hs = x_valid & x_ready.
    - On hs: mem_ren=1 (combinational), mem_radd=addr, x_q<=x_data, v_q<=1, last_q<=(addr==NUM_WEIGHT-1), addr<=addr+1.
    - With no hs: mem_ren=0, v_q<=0.
    - If hs and addr==NUM_WEIGHT-1 → DRAIN.
  - DRAIN: x_ready=0, mem_ren=0, v_q<=0; the final pair is presented this cycle → DONE.
  - DONE: done=1 for exactly one cycle, addr<=0 → IDLE.
- Outputs: pair_valid=v_q, pair_x=x_q, pair_last=v_q&last_q, pair_w=mem_rdata.
- Latency:
  - Activation accepted at edge t → pair at cycle t+1.
  - Last handshake at t → pair_last at t+1, done at t+2.
  - A back-to-back stream of 30 yields 30 consecutive pair_valid cycles.
- Stalls: x_valid=0 in RUN produces a bubble. The ROM is not read (mem_ren=0), so mem_rdata holds, and pair_valid=0 that cycle. No downstream backpressure; the MAC must accept every pair_valid.
- Address:
  - Never exceeds NUM_WEIGHT-1.
  - No wrap within one evaluation.
  - Each index is read exactly once, in ascending order.
- start while busy or in DONE: ignored, no effect on count.
- start and abort same cycle in IDLE: abort wins, stay IDLE.
- abort in RUN/DRAIN/DONE: next state IDLE, addr<=0, v_q<=0, no done pulse. A handshake in the abort cycle is discarded (x_ready is forced 0 when abort=1).
- rst_n deasserted mid-evaluation: immediate clear to the reset values; no partial pair or done is emitted.
- NUM_WEIGHT=1 is legal: RUN→DRAIN on the first handshake, and that pair has pair_last=1.

Test Plan:
- Reset then start with continuous x_valid, x_data=k+1 for k=0..29, ROM mem[k]=k*3 → pairs (w=3k, x=k+1) on 30 consecutive cycles starting 1 cycle after the first handshake; pair_last only on (87,30); done exactly 2 cycles after the last handshake; busy low the cycle done is high.
- Same run with x_valid low on cycles 5 and 12–14 → mem_ren low on exactly those cycles, pair_valid gaps are 1-cycle delayed, all 30 pairs are correct and in order, radd sequence is 0..29 with no repeats.
- start pulsed at activation 10 and again during DONE → no restart, pair count stays 30, single done pulse.
- abort after 17 handshakes → IDLE next edge, no pair_last, no done; a following start produces a full clean 30-pair run beginning at radd=0.
- rst_n low for 1 cycle asynchronously at activation 20 → all outputs 0 immediately; after release, stays IDLE until start; next run is correct.
- NUM_WEIGHT=1 build → single pair with pair_last=1, done 2 cycles after the handshake.
